// File: rtl/vedic_mult_iter.sv
// ----------------------------------------------------------------------------
// vedic_mult_iter -- multi-cycle Urdhva-Tiryagbhyam (Vedic) multiplier.
//
// Each WIDTH-bit operand is split into halves. One combinational
// (WIDTH/2)x(WIDTH/2) Vedic core is reused over four cycles. The four partial
// products are added into a 2*WIDTH accumulator, and the result is handed to
// the sink through a valid/ready handshake.
//
// Optional feature macro: VEDIC_SIGNED_EN
//   When defined, an extra input `sgn` selects two's-complement operands.
//   The core always multiplies magnitudes. The sign is applied when the final
//   sum is loaded into c.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   a/b are valid
//   in_ready   operands can be accepted this cycle (combinational)
//   a, b       WIDTH-bit multiplicand / multiplier
//   sgn        (VEDIC_SIGNED_EN only) 1 = signed operands, sampled at accept
//   out_valid  c holds a completed product
//   out_ready  sink takes c this cycle
//   c          2*WIDTH-bit registered product
//   busy       high whenever the FSM is not idle
//
// vedic_core -- recursive NxN Vedic multiplier, built down to 2x2 cells.
// ----------------------------------------------------------------------------

module vedic_core #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_cell
    // 2x2 Urdhva cell: vertical, crosswise, vertical.
    logic cross_c;
    assign p[0]    = x[0] & y[0];
    assign p[1]    = (x[1] & y[0]) ^ (x[0] & y[1]);
    assign cross_c = (x[1] & y[0]) & (x[0] & y[1]);
    assign p[2]    = (x[1] & y[1]) ^ cross_c;
    assign p[3]    = (x[1] & y[1]) & cross_c;
  end else begin : g_rec
    localparam int unsigned M = N / 2;

    logic [N-1:0] q_ll;
    logic [N-1:0] q_hl;
    logic [N-1:0] q_lh;
    logic [N-1:0] q_hh;

    vedic_core #(.N(M)) u_ll (.x(x[M-1:0]), .y(y[M-1:0]), .p(q_ll));
    vedic_core #(.N(M)) u_hl (.x(x[N-1:M]), .y(y[M-1:0]), .p(q_hl));
    vedic_core #(.N(M)) u_lh (.x(x[M-1:0]), .y(y[N-1:M]), .p(q_lh));
    vedic_core #(.N(M)) u_hh (.x(x[N-1:M]), .y(y[N-1:M]), .p(q_hh));

    // The two cross terms sit at weight 2^M. The high term sits at 2^N.
    assign p = {{N{1'b0}}, q_ll}
             + {{M{1'b0}}, q_hl, {M{1'b0}}}
             + {{M{1'b0}}, q_lh, {M{1'b0}}}
             + {q_hh, {N{1'b0}}};
  end

endmodule

module vedic_mult_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef VEDIC_SIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [W2-1:0]    acc_q;

  logic             accept;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;
  logic [H-1:0]     core_x;
  logic [H-1:0]     core_y;
  logic [WIDTH-1:0] pp;
  logic [W2-1:0]    pp_ext;
  logic [W2-1:0]    addend;
  logic [W2-1:0]    sum;
  logic [W2-1:0]    result;

  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign busy     = (state_q != StIdle);
  assign accept   = in_valid & in_ready;

`ifdef VEDIC_SIGNED_EN
  logic neg_q;
  logic neg_load;

  // Magnitudes go to the core. -2^(WIDTH-1) negates to itself, and that is
  // the correct unsigned magnitude.
  assign a_load   = (sgn & a[WIDTH-1]) ? -a : a;
  assign b_load   = (sgn & b[WIDTH-1]) ? -b : b;
  assign neg_load = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign result   = neg_q ? -sum : sum;
`else
  assign a_load   = a;
  assign b_load   = b;
  assign result   = sum;
`endif

  // Pick the operand halves for the current partial-product step.
  always_comb begin
    core_x = op_a_q[H-1:0];
    core_y = op_b_q[H-1:0];
    unique case (state_q)
      StP1: core_y = op_b_q[WIDTH-1:H];
      StP2: core_x = op_a_q[WIDTH-1:H];
      StP3: begin
        core_x = op_a_q[WIDTH-1:H];
        core_y = op_b_q[WIDTH-1:H];
      end
      default: ;
    endcase
  end

  vedic_core #(.N(H)) u_core (
    .x (core_x),
    .y (core_y),
    .p (pp)
  );

  assign pp_ext = {{WIDTH{1'b0}}, pp};

  always_comb begin
    addend = pp_ext;
    unique case (state_q)
      StP1, StP2: addend = pp_ext << H;
      StP3:       addend = pp_ext << WIDTH;
      default:    ;
    endcase
  end

  // The product of two WIDTH-bit magnitudes fits in 2*WIDTH bits, so this
  // add never carries out.
  assign sum = acc_q + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      c         <= '0;
      acc_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
`ifdef VEDIC_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      // accept can only be true in StIdle or StDone. It never collides with
      // the accumulator updates in P0..P3.
      if (accept) begin
        op_a_q <= a_load;
        op_b_q <= b_load;
        acc_q  <= '0;
`ifdef VEDIC_SIGNED_EN
        neg_q  <= neg_load;
`endif
      end

      unique case (state_q)
        StIdle: begin
          if (in_valid) state_q <= StP0;
        end
        StP0: begin
          acc_q   <= sum;
          state_q <= StP1;
        end
        StP1: begin
          acc_q   <= sum;
          state_q <= StP2;
        end
        StP2: begin
          acc_q   <= sum;
          state_q <= StP3;
        end
        StP3: begin
          acc_q     <= sum;
          c         <= result;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= in_valid ? StP0 : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
